// File: rtl/keypad_pkg.sv
// Shared keypad constants and the entry FSM state type.
// Key codes are the scanner's 5-bit codes: 0-15 are keys, 16 means no key held.
package keypad_pkg;

  localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;
  localparam logic [4:0] KEY_CLR       = 5'd10;
  localparam logic [4:0] KEY_BS        = 5'd11;
  localparam logic [4:0] KEY_ENT       = 5'd12;
  localparam logic [4:0] KEY_MODE      = 5'd13;
  localparam logic [4:0] KEY_NONE      = 5'd16;

  typedef enum logic [1:0] {
    StEntry   = 2'd0,
    StConvert = 2'd1,
    StCommit  = 2'd2
  } entry_state_e;

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad entry bus: scanner key stream in, BCD buffer and committed control words out.
//   master: the scanner/consumer side (drives key, keypress; observes results)
//   slave : keypad_entry (consumes key, keypress; drives everything else)
interface keypad_entry_if #(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned PHASE_W = 12
);
  localparam int unsigned CntW = $clog2(DIGITS + 1);

  logic [4:0]          key;
  logic                keypress;
  logic [4*DIGITS-1:0] digits_bcd;
  logic [CntW-1:0]     digit_count;
  logic                busy;
  logic [OUT_W-1:0]    freq_word;
  logic [PHASE_W-1:0]  phase_word;
  logic                mode;
  logic                out_valid;

  modport master (
    output key, keypress,
    input  digits_bcd, digit_count, busy, freq_word, phase_word, mode, out_valid
  );

  modport slave (
    input  key, keypress,
    output digits_bcd, digit_count, busy, freq_word, phase_word, mode, out_valid
  );
endinterface

// File: rtl/bcd_serial_to_bin.sv
// Serial BCD-to-binary converter: one digit per cycle, acc = acc*10 + digit,
// walking from the most significant held digit (nibble count-1) down to nibble 0.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   start_i       : load acc=0 and idx=count_i-1, begin converting next cycle
//   count_i       : number of valid digits (must be > 0 when start_i is high)
//   digits_i      : BCD digits, newest in nibble 0; must stay stable while converting
//   acc_o         : running / final binary value, truncated to OUT_W
//   done_o        : high in the cycle that accumulates the last digit
module bcd_serial_to_bin #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned OUT_W  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [$clog2(DIGITS+1)-1:0]  count_i,
  input  logic [4*DIGITS-1:0]          digits_i,
  output logic [OUT_W-1:0]             acc_o,
  output logic                         done_o
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [IdxW-1:0]  idx_q, idx_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             run_q, run_d;
  logic [3:0]       digit;

  assign digit = digits_i[{idx_q, 2'b00} +: 4];

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    run_d = run_q;
    if (start_i) begin
      acc_d = '0;
      idx_d = IdxW'(count_i - 1'b1);
      run_d = 1'b1;
    end else if (run_q) begin
      // x10 as shift-and-add; wraps modulo 2^OUT_W
      acc_d = (acc_q << 3) + (acc_q << 1) + OUT_W'(digit);
      if (idx_q == '0) begin
        run_d = 1'b0;
      end else begin
        idx_d = idx_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      run_q <= run_d;
    end
  end

  assign acc_o  = acc_q;
  assign done_o = run_q && (idx_q == '0);

endmodule

// File: rtl/keypad_entry.sv
// Keypad decimal entry: collects digit keys into a BCD buffer (newest digit in nibble 0),
// converts on Enter (one digit per cycle) and commits the result as the frequency word,
// or the phase word when KEYPAD_ENTRY_PHASE_EN is defined and mode is 1.
// Ports:
//   clk     : system clock
//   reset_n : async active-low reset; clears everything, aborts a conversion
//   kp      : keypad_entry_if slave (key/keypress in; buffer, busy, words, mode, out_valid out)
// Build option: KEYPAD_ENTRY_PHASE_EN enables key 13 (mode toggle) and the phase word;
// without it mode and phase_word are tied to 0.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned PHASE_W = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  keypad_entry_if.slave kp
);

  localparam int unsigned CntW = $clog2(DIGITS + 1);
  localparam logic [CntW-1:0] CountMax = CntW'(DIGITS);

  entry_state_e        state_q, state_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [OUT_W-1:0]    freq_q, freq_d;
  logic                out_valid_q, out_valid_d;
  logic                conv_start;
  logic                conv_done;
  logic [OUT_W-1:0]    conv_acc;
  logic                accept;

`ifdef KEYPAD_ENTRY_PHASE_EN
  logic               mode_q, mode_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
`endif

  // key[4] set means "no key"; keys are only taken while idle in entry
  assign accept = kp.keypress && (kp.key < KEY_NONE) && (state_q == StEntry);

  bcd_serial_to_bin #(
    .DIGITS (DIGITS),
    .OUT_W  (OUT_W)
  ) u_conv (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .start_i  (conv_start),
    .count_i  (count_q),
    .digits_i (digits_q),
    .acc_o    (conv_acc),
    .done_o   (conv_done)
  );

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    count_d     = count_q;
    freq_d      = freq_q;
    out_valid_d = 1'b0;
    conv_start  = 1'b0;
`ifdef KEYPAD_ENTRY_PHASE_EN
    mode_d      = mode_q;
    phase_d     = phase_q;
`endif

    unique case (state_q)
      StEntry: begin
        if (accept) begin
          if (kp.key <= KEY_DIGIT_MAX) begin
            if (count_q < CountMax) begin
              digits_d = {digits_q[4*DIGITS-5:0], kp.key[3:0]};
              count_d  = count_q + 1'b1;
            end
          end else begin
            case (kp.key)
              KEY_CLR: begin
                digits_d = '0;
                count_d  = '0;
              end
              KEY_BS: begin
                if (count_q != '0) begin
                  digits_d = {4'h0, digits_q[4*DIGITS-1:4]};
                  count_d  = count_q - 1'b1;
                end
              end
              KEY_ENT: begin
                if (count_q != '0) begin
                  conv_start = 1'b1;
                  state_d    = StConvert;
                end
              end
              KEY_MODE: begin
`ifdef KEYPAD_ENTRY_PHASE_EN
                mode_d = ~mode_q;
`endif
              end
              default: ;
            endcase
          end
        end
      end
      StConvert: begin
        if (conv_done) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
`ifdef KEYPAD_ENTRY_PHASE_EN
        if (mode_q) begin
          phase_d = conv_acc[PHASE_W-1:0];
        end else begin
          freq_d = conv_acc;
        end
`else
        freq_d = conv_acc;
`endif
        out_valid_d = 1'b1;
        digits_d    = '0;
        count_d     = '0;
        state_d     = StEntry;
      end
      default: state_d = StEntry;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StEntry;
      digits_q    <= '0;
      count_q     <= '0;
      freq_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      count_q     <= count_d;
      freq_q      <= freq_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef KEYPAD_ENTRY_PHASE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
    end
  end

  assign kp.mode       = mode_q;
  assign kp.phase_word = phase_q;
`else
  assign kp.mode       = 1'b0;
  assign kp.phase_word = {PHASE_W{1'b0}};
`endif

  assign kp.digits_bcd  = digits_q;
  assign kp.digit_count = count_q;
  assign kp.busy        = (state_q != StEntry);
  assign kp.freq_word   = freq_q;
  assign kp.out_valid   = out_valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
module tb_keypad_entry;
  import keypad_pkg::*;

  localparam int unsigned DIGITS  = 8;
  localparam int unsigned OUT_W   = 32;
  localparam int unsigned PHASE_W = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  keypad_entry_if #(.DIGITS(DIGITS), .OUT_W(OUT_W), .PHASE_W(PHASE_W)) kp ();

  keypad_entry #(.DIGITS(DIGITS), .OUT_W(OUT_W), .PHASE_W(PHASE_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kp      (kp)
  );

  int passes = 0;
  int total  = 0;

  // Reference model: digits in entry order (oldest first)
  int          q[$];
  logic        mode_m;
  longint unsigned freq_m;
  longint unsigned phase_m;

`ifdef KEYPAD_ENTRY_PHASE_EN
  localparam bit PhaseEn = 1'b1;
`else
  localparam bit PhaseEn = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [4*DIGITS-1:0] model_bcd();
    logic [4*DIGITS-1:0] b = '0;
    for (int i = 0; i < q.size(); i++) begin
      int d = q[q.size() - 1 - i];
      b[4*i +: 4] = 4'(d);
    end
    return b;
  endfunction

  function automatic longint unsigned model_value();
    longint unsigned v = 0;
    foreach (q[i]) v = (v * 10 + longint'(q[i])) % (64'd1 << OUT_W);
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    mode_m  = 1'b0;
    freq_m  = 0;
    phase_m = 0;
  endtask

  task automatic model_key(input int k);
    if (k <= 9) begin
      if (q.size() < DIGITS) q.push_back(k);
    end else if (k == 10) begin
      q.delete();
    end else if (k == 11) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (k == 13 && PhaseEn) begin
      mode_m = ~mode_m;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_bcd"},   kp.digits_bcd, model_bcd());
    chk({tag, "_count"}, kp.digit_count, q.size());
    chk({tag, "_busy"},  kp.busy, 0);
    chk({tag, "_valid"}, kp.out_valid, 0);
    chk({tag, "_freq"},  kp.freq_word, freq_m);
    chk({tag, "_phase"}, kp.phase_word, phase_m);
    chk({tag, "_mode"},  kp.mode, mode_m);
  endtask

  // Called just after accepting edge E; walks E+1 .. E+n+2
  task automatic wait_commit(input int n, input bit inject);
    longint unsigned v = model_value();
    chk("ent_busy", kp.busy, 1);
    chk("ent_valid", kp.out_valid, 0);
    if (inject) begin
      kp.key = 5'($urandom_range(0, 15));
      kp.keypress = 1'b1;
    end
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      kp.keypress = 1'b0;
      kp.key = KEY_NONE;
      chk("conv_busy", kp.busy, 1);
      chk("conv_valid", kp.out_valid, 0);
    end
    @(posedge clk); #1;
    if (mode_m) phase_m = v % (64'd1 << PHASE_W);
    else freq_m = v;
    q.delete();
    chk("commit_valid", kp.out_valid, 1);
    chk("commit_busy", kp.busy, 0);
    chk("commit_freq", kp.freq_word, freq_m);
    chk("commit_phase", kp.phase_word, phase_m);
    chk("commit_count", kp.digit_count, 0);
    chk("commit_bcd", kp.digits_bcd, 0);
    @(posedge clk); #1;
    chk("post_valid", kp.out_valid, 0);
  endtask

  task automatic press(input int k);
    @(negedge clk);
    kp.key = 5'(k);
    kp.keypress = 1'b1;
    @(posedge clk); #1;
    kp.keypress = 1'b0;
    kp.key = KEY_NONE;
    if (k == 12 && q.size() > 0) wait_commit(q.size(), 1'($urandom_range(0, 1)));
    else begin
      model_key(k);
      check_idle("key");
    end
  endtask

  initial begin
    int k;
    int r;
    kp.key = KEY_NONE;
    kp.keypress = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // 1234
    press(1); press(2); press(3); press(4); press(12);
    chk("freq_1234", kp.freq_word, 1234);

    // 5,6,7,BS,8 -> 568; backspace on empty is a no-op
    press(5); press(6); press(7); press(11); press(8); press(12);
    chk("freq_568", kp.freq_word, 568);
    press(11);

    // nine 9s: 9th ignored
    repeat (9) press(9);
    chk("full_count", kp.digit_count, DIGITS);
    press(12);
    chk("freq_9s", kp.freq_word, 99999999);

    // ignored keys and empty Enter
    press(16); press(14); press(15); press(12);
    press(3); press(10);
    chk("clr_count", kp.digit_count, 0);

    // mode / phase sequence
    press(13); press(2); press(0); press(4); press(8); press(12);
    if (PhaseEn) begin
      chk("phase_2048", kp.phase_word, 2048);
      press(13);
    end else begin
      chk("freq_2048", kp.freq_word, 2048);
    end

    // randomized key stream
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      k = (r < 65) ? (r % 10) : int'($urandom_range(10, 16));
      press(k);
    end

    // reset mid-conversion after a commit of 1234
    press(1); press(2); press(3); press(4); press(12);
    press(5); press(6);
    @(negedge clk);
    kp.key = KEY_ENT;
    kp.keypress = 1'b1;
    @(posedge clk); #1;
    kp.keypress = 1'b0;
    kp.key = KEY_NONE;
    chk("abort_busy_pre", kp.busy, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("abort_busy", kp.busy, 0);
    chk("abort_freq", kp.freq_word, 0);
    chk("abort_count", kp.digit_count, 0);
    chk("abort_bcd", kp.digits_bcd, 0);
    chk("abort_valid", kp.out_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    check_idle("after_rst");
    press(7); press(12);
    chk("freq_7", kp.freq_word, 7);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Consumes the `key` / `keypress` stream from the matrix keypad scanner and assembles decimal digit entry into binary control words for the DDS core. Digits are held as BCD for display. On Enter, the digits are converted serially to binary (one digit per cycle) and the frequency word is loaded with a one-cycle `out_valid` strobe. The block sits between the keypad scanner and the DDS phase accumulator/register file.

## Interface
- `DIGITS`, default 8: maximum entered decimal digits.
- `OUT_W`, default 32: frequency word width. Must satisfy `OUT_W >= ceil(DIGITS*3.33)`.
- `PHASE_W`, default 12: phase word width (only used with the phase feature).
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `key`  in  5  scanner key code: 0–15 is a key, 16 (`5'b10000`) is no key.
- `keypress`  in  1  one-cycle strobe, high when `key` holds a new value.
- `digits_bcd`  out  4*DIGITS  entered digits; newest digit is in nibble 0.
- `digit_count`  out  $clog2(DIGITS+1)  number of digits held.
- `busy`  out  1  conversion in progress.
- `freq_word`  out  OUT_W  last committed frequency word.
- `phase_word`  out  PHASE_W  last committed phase word.
- `mode`  out  1  entry target: 0 = frequency, 1 = phase.
- `out_valid`  out  1  one-cycle strobe when `freq_word` or `phase_word` updates.

## Operation
- A key is accepted only in the cycle `keypress==1 && key[4]==0 && state==ENTRY`. Every other `keypress` is ignored, including release (`key==16`) and any key during CONVERT.
- Key map:
  - 0–9: digit. If `digit_count<DIGITS`, shift `digits_bcd` left one nibble, insert the digit at nibble 0, and increment `digit_count`. If the buffer is full, the digit is ignored.
  - 10: clear. Zero `digits_bcd` and `digit_count`.
  - 11: backspace. Shift right one nibble, zero-filling the top, and decrement the count. No-op when the count is 0.
  - 12: enter. If `digit_count>0`, go to CONVERT. If `digit_count==0`, ignored.
  - 13: toggle `mode` (phase feature only).
  - 14, 15: ignored.
- FSM states: ENTRY, CONVERT, COMMIT.
  - ENTRY -> CONVERT on an accepted Enter. Load `acc<=0` and `idx<=digit_count-1`.
  - CONVERT: each cycle, `acc <= acc*10 + digits_bcd[idx]`. The multiply is implemented as `(acc<<3)+(acc<<1)`, truncated to OUT_W. When `idx==0`, go to COMMIT; otherwise decrement `idx`.
  - COMMIT (one cycle):
    - If `mode==0`, `freq_word<=acc`. If `mode==1`, `phase_word<=acc[PHASE_W-1:0]`.
    - Pulse `out_valid`.
    - Clear `digits_bcd` and `digit_count`.
    - Return to ENTRY.
- `mode` is unchanged by commit and clear.
- Reset (asynchronous, any state): all outputs 0, FSM = ENTRY, `acc=0`. A conversion in flight is aborted, and the previously committed words are lost.

## Timing
- Digit, clear and backspace update `digits_bcd` and `digit_count` on the edge that samples the accepted `keypress`.
- Enter with n digits:
  - `busy` rises on the accepting edge E.
  - CONVERT occupies edges E+1 .. E+n.
  - COMMIT updates the word and raises `out_valid` at edge E+n+1.
  - `busy` falls and the buffer clears at that same edge.
- `out_valid` is high for exactly one cycle.
- The block is ready for new keys in the cycle after `out_valid`.
- No input registering is needed: the scanner's `key` and `keypress` are already registered in the `clk` domain.

## Configuration
- `KEYPAD_ENTRY_PHASE_EN` defined: key 13 toggles `mode`, and COMMIT targets `phase_word` when `mode==1`.
- `KEYPAD_ENTRY_PHASE_EN` undefined: key 13 is ignored. `mode` and `phase_word` are tied to 0, and every commit targets `freq_word`.

## Structure
- Shared package `keypad_pkg`:
  - Key-code constants: `KEY_NONE=16`, `KEY_CLR=10`, `KEY_BS=11`, `KEY_ENT=12`, `KEY_MODE=13`.
  - The FSM state enum (ENTRY, CONVERT, COMMIT).
  - This package is also the home for the scanner's code constants.
- One natural sub-module, `bcd_serial_to_bin`: the acc*10+digit datapath with `start`/`done`, parameterised on OUT_W and DIGITS. Buffer handling and the FSM stay in `keypad_entry`.

## Test plan
- Keys 1,2,3,4,Enter, each as a single `keypress` -> `busy` high for 5 cycles, then `freq_word=1234` with one `out_valid` at edge E+5, and `digit_count=0`.
- Keys 5,6,7, backspace, 8, Enter -> `freq_word=568`. Backspace with `digit_count=0` -> no change to any output.
- Keys 9 ×9 (DIGITS=8), Enter -> 9th digit ignored, `freq_word=99999999`, commit at edge E+9.
- `keypress` with `key=16`, keys 14/15, and Enter on an empty buffer -> no state change and no `out_valid`. A key pressed during CONVERT is ignored and the result is unaffected.
- With `KEYPAD_ENTRY_PHASE_EN`: keys 13,2,0,4,8, Enter (PHASE_W=12) -> `phase_word=2048`, `freq_word` unchanged. Without the macro, the same sequence -> `freq_word=2048`.
- Drive `reset_n` low mid-CONVERT after a prior commit of 1234 -> all outputs 0 immediately. After release, entering 7, Enter -> `freq_word=7`.
